bench_timer_ctrl: RTL and testbench
===================================

Name: bench_timer_ctrl

Overview:
- Sequencing controller for the two-channel benchmark timer.
- Turns single-cycle start/stop/clear events from the LEIA core's benchmark hooks into the level-sensitive `t1_ena`/`t2_ena` enables for the timer/seven-segment display.
- Keeps an exact 32-bit cycle count per channel for readback.
- Enforces nesting of channel 2 inside channel 1 and auto-stops a channel on timeout.

Parameters:
- CYCLE_W, 32: width of each cycle counter.
- TIMEOUT_CYCLES, 1000000000: max enabled cycles per channel (10 s at 100 MHz, the display wrap point); must be < 2^CYCLE_W.
- NEST_T2, 1: 1 = channel 2 may only run while channel 1 runs; 0 = channels independent.

Ports:
- CLK100MHZ  in  1  system clock, all logic on rising edge
- btn_reset  in  1  synchronous reset, active-high
- start_1  in  1  single-cycle pulse, start channel 1
- stop_1  in  1  single-cycle pulse, stop channel 1
- start_2  in  1  single-cycle pulse, start channel 2
- stop_2  in  1  single-cycle pulse, stop channel 2
- clear  in  1  single-cycle pulse, return both channels to IDLE
- t1_ena  out  1  channel 1 enable to timer; high exactly while ch1 in RUN
- t2_ena  out  1  channel 2 enable to timer; high exactly while ch2 in RUN
- cycles_1  out  CYCLE_W  channel 1 elapsed enabled cycles
- cycles_2  out  CYCLE_W  channel 2 elapsed enabled cycles
- done_1  out  1  channel 1 in DONE
- done_2  out  1  channel 2 in DONE
- timeout_1  out  1  channel 1 stopped by timeout
- timeout_2  out  1  channel 2 stopped by timeout
- busy  out  1  t1_ena | t2_ena

Behaviour:
- Reset:
  - btn_reset=1 at an edge forces both channels to IDLE and drives every output to 0 on the next cycle.
  - Reset dominates all other inputs, including mid-RUN.
- Per-channel FSM states: IDLE, RUN, DONE. All outputs are registered.
- IDLE:
  - start -> RUN and count <= 0. Enable is high from the cycle after start is sampled.
  - stop is ignored. start+stop in the same cycle -> RUN.
- RUN:
  - Enable = 1 and count <= count+1 every cycle, including the cycle in which stop is sampled.
  - stop -> DONE; enable low from the next cycle; count holds.
  - Result: start sampled at cycle N, stop at cycle M gives enable high for cycles N+1..M and a final count of M-N.
  - start while in RUN is ignored (no restart).
- Timeout:
  - In RUN, if count == TIMEOUT_CYCLES-1 at an edge, then count <= TIMEOUT_CYCLES, state -> DONE, timeout_x <= 1.
  - Timeout has priority over a simultaneous stop (flag set, same count).
- DONE:
  - done_x=1; count and timeout_x hold.
  - start and stop are ignored; only clear or reset leave DONE.
- clear:
  - From any state, both channels -> IDLE, counts <= 0, done/timeout <= 0, enables low next cycle (aborts RUN).
  - clear has priority over start/stop in the same cycle.
- NEST_T2=1:
  - start_2 is accepted only if ch1 is in RUN at that edge (not the edge on which ch1 enters RUN); otherwise it is ignored.
  - If ch1 leaves RUN (stop_1 or timeout) while ch2 is in RUN, ch2 -> DONE on the same edge. Its count includes that cycle; timeout_2 is unchanged.
  - start_1 in the same cycle as start_2 from IDLE: ch1 starts, start_2 is ignored.
- NEST_T2=0: the channels are fully independent.
- Counters never wrap; the maximum value is TIMEOUT_CYCLES.
- Pulses held high for multiple cycles behave as repeated pulses, which the rules above make idempotent.

Test Plan:
- Basic: reset, then start_1 at cycle 10 and stop_1 at cycle 110 -> t1_ena high for cycles 11..110, cycles_1=100, done_1=1, timeout_1=0.
- Nesting (NEST_T2=1): start_1@10, start_2@20, stop_2@50, stop_1@80 -> cycles_2=30, cycles_1=70. A start_2 before start_1 is ignored (t2_ena stays 0).
- Forced stop: start_1@10, start_2@20, stop_1@60 -> both DONE on the same edge, cycles_2=40, t2_ena low from cycle 61.
- Timeout: TIMEOUT_CYCLES=50, start_1@5, no stop -> t1_ena low from cycle 56, cycles_1=50, timeout_1=1. A stop_1 at cycle 55 gives the same result.
- Clear and reset: clear during RUN -> enables low next cycle, all counts/flags 0, a fresh start works. btn_reset mid-RUN -> identical result; start/stop sampled during reset are ignored.
- Ignored events: start_1 while in RUN or DONE, and stop_1 in IDLE -> no change in state or count.

Source files
------------

// File: rtl/bench_timer_ctrl.sv
// bench_timer_ctrl: two-channel benchmark timer sequencer with nesting and timeout auto-stop
module bench_timer_ctrl #(
    parameter int unsigned CYCLE_W        = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1000000000,
    parameter bit          NEST_T2        = 1'b1
) (
    input  logic               CLK100MHZ,
    input  logic               btn_reset,
    input  logic               start_1,
    input  logic               stop_1,
    input  logic               start_2,
    input  logic               stop_2,
    input  logic               clear,
    output logic               t1_ena,
    output logic               t2_ena,
    output logic [CYCLE_W-1:0] cycles_1,
    output logic [CYCLE_W-1:0] cycles_2,
    output logic               done_1,
    output logic               done_2,
    output logic               timeout_1,
    output logic               timeout_2,
    output logic               busy
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [CYCLE_W-1:0] TO_MAX  = CYCLE_W'(TIMEOUT_CYCLES);
    localparam logic [CYCLE_W-1:0] TO_LAST = CYCLE_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CYCLE_W-1:0] ONE     = CYCLE_W'(1);

    state_t             st1_q, st1_d, st2_q, st2_d;
    logic [CYCLE_W-1:0] cnt1_q, cnt1_d, cnt2_q, cnt2_d;
    logic               to1_q, to1_d, to2_q, to2_d;
    logic               hit1, hit2, end1;

    assign cycles_1  = cnt1_q;
    assign cycles_2  = cnt2_q;
    assign timeout_1 = to1_q;
    assign timeout_2 = to2_q;

    // Next state for both channels; ch1 leaving RUN drags a running ch2 to DONE when nested
    always_comb begin
        hit1   = st1_q == RUN && cnt1_q == TO_LAST;
        hit2   = st2_q == RUN && cnt2_q == TO_LAST;
        end1   = st1_q == RUN && (stop_1 || hit1);
        st1_d  = st1_q;
        st2_d  = st2_q;
        cnt1_d = cnt1_q;
        cnt2_d = cnt2_q;
        to1_d  = to1_q;
        to2_d  = to2_q;
        if (clear) begin
            st1_d  = IDLE;
            st2_d  = IDLE;
            cnt1_d = '0;
            cnt2_d = '0;
            to1_d  = 1'b0;
            to2_d  = 1'b0;
        end else begin
            case (st1_q)
                IDLE: if (start_1) begin
                    st1_d  = RUN;
                    cnt1_d = '0;
                end
                RUN: begin
                    cnt1_d = hit1 ? TO_MAX : cnt1_q + ONE;
                    to1_d  = hit1;
                    st1_d  = end1 ? DONE : RUN;
                end
                default: ;
            endcase
            case (st2_q)
                IDLE: if (start_2 && (!NEST_T2 || st1_q == RUN)) begin
                    st2_d  = RUN;
                    cnt2_d = '0;
                end
                RUN: begin
                    cnt2_d = hit2 ? TO_MAX : cnt2_q + ONE;
                    to2_d  = hit2;
                    st2_d  = (stop_2 || hit2 || (NEST_T2 && end1)) ? DONE : RUN;
                end
                default: ;
            endcase
        end
    end

    // State, counters and registered status outputs
    always_ff @(posedge CLK100MHZ) begin
        if (btn_reset) begin
            st1_q  <= IDLE;
            st2_q  <= IDLE;
            cnt1_q <= '0;
            cnt2_q <= '0;
            to1_q  <= 1'b0;
            to2_q  <= 1'b0;
            t1_ena <= 1'b0;
            t2_ena <= 1'b0;
            done_1 <= 1'b0;
            done_2 <= 1'b0;
            busy   <= 1'b0;
        end else begin
            st1_q  <= st1_d;
            st2_q  <= st2_d;
            cnt1_q <= cnt1_d;
            cnt2_q <= cnt2_d;
            to1_q  <= to1_d;
            to2_q  <= to2_d;
            t1_ena <= st1_d == RUN;
            t2_ena <= st2_d == RUN;
            done_1 <= st1_d == DONE;
            done_2 <= st2_d == DONE;
            busy   <= st1_d == RUN || st2_d == RUN;
        end
    end

endmodule

// File: tb/tb_bench_timer_ctrl.sv
// tb_bench_timer_ctrl: directed checks of sequencing, nesting, timeout, clear and reset
module tb_bench_timer_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [4:0] ev = '0;  // {clear, stop_2, start_2, stop_1, start_1}
    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [4:0] S1 = 5'b00001, P1 = 5'b00010, S2 = 5'b00100, P2 = 5'b01000, CLR = 5'b10000;

    // main: nested, long timeout; tmo: nested, timeout 50; ind: independent channels
    logic m_t1, m_t2, m_d1, m_d2, m_o1, m_o2, m_b;
    logic t_t1, t_t2, t_d1, t_d2, t_o1, t_o2, t_b;
    logic i_t1, i_t2, i_d1, i_d2, i_o1, i_o2, i_b;
    logic [31:0] m_c1, m_c2, t_c1, t_c2, i_c1, i_c2;

    always #5 clk = ~clk;

    bench_timer_ctrl #(.CYCLE_W(32), .TIMEOUT_CYCLES(1000), .NEST_T2(1'b1)) dut (
        .CLK100MHZ(clk), .btn_reset(rst), .start_1(ev[0]), .stop_1(ev[1]), .start_2(ev[2]),
        .stop_2(ev[3]), .clear(ev[4]), .t1_ena(m_t1), .t2_ena(m_t2), .cycles_1(m_c1),
        .cycles_2(m_c2), .done_1(m_d1), .done_2(m_d2), .timeout_1(m_o1), .timeout_2(m_o2), .busy(m_b)
    );

    bench_timer_ctrl #(.CYCLE_W(32), .TIMEOUT_CYCLES(50), .NEST_T2(1'b1)) dut_tmo (
        .CLK100MHZ(clk), .btn_reset(rst), .start_1(ev[0]), .stop_1(ev[1]), .start_2(ev[2]),
        .stop_2(ev[3]), .clear(ev[4]), .t1_ena(t_t1), .t2_ena(t_t2), .cycles_1(t_c1),
        .cycles_2(t_c2), .done_1(t_d1), .done_2(t_d2), .timeout_1(t_o1), .timeout_2(t_o2), .busy(t_b)
    );

    bench_timer_ctrl #(.CYCLE_W(32), .TIMEOUT_CYCLES(1000), .NEST_T2(1'b0)) dut_ind (
        .CLK100MHZ(clk), .btn_reset(rst), .start_1(ev[0]), .stop_1(ev[1]), .start_2(ev[2]),
        .stop_2(ev[3]), .clear(ev[4]), .t1_ena(i_t1), .t2_ena(i_t2), .cycles_1(i_c1),
        .cycles_2(i_c2), .done_1(i_d1), .done_2(i_d2), .timeout_1(i_o1), .timeout_2(i_o2), .busy(i_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic pulse(input logic [4:0] e);
        ev = e;
        step();
        ev = '0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " t1_ena"}, {31'd0, m_t1}, 0);
        check({tag, " t2_ena"}, {31'd0, m_t2}, 0);
        check({tag, " cycles_1"}, m_c1, 0);
        check({tag, " cycles_2"}, m_c2, 0);
        check({tag, " done_1"}, {31'd0, m_d1}, 0);
        check({tag, " done_2"}, {31'd0, m_d2}, 0);
        check({tag, " busy"}, {31'd0, m_b}, 0);
    endtask

    initial begin
        idle(3);
        check_all_zero("reset");
        check("reset timeout_1", {31'd0, m_o1}, 0);
        rst = 1'b0;
        step();

        // stop in IDLE ignored; start_2 without ch1 ignored only when nested
        pulse(P1);
        check("idle stop done_1", {31'd0, m_d1}, 0);
        pulse(S2);
        check("lone start_2 nested t2_ena", {31'd0, m_t2}, 0);
        check("lone start_2 indep t2_ena", {31'd0, i_t2}, 1);
        pulse(CLR);
        check("clear indep t2_ena", {31'd0, i_t2}, 0);

        // basic run of 100 cycles with a start retrigger mid-run
        pulse(S1);
        check("basic t1_ena", {31'd0, m_t1}, 1);
        check("basic busy", {31'd0, m_b}, 1);
        check("basic count start", m_c1, 0);
        idle(49);
        pulse(S1);
        check("run restart ignored", m_c1, 50);
        check("tmo cycles_1", t_c1, 50);
        check("tmo timeout_1", {31'd0, t_o1}, 1);
        check("tmo t1_ena", {31'd0, t_t1}, 0);
        idle(49);
        pulse(P1);
        check("basic cycles_1", m_c1, 100);
        check("basic done_1", {31'd0, m_d1}, 1);
        check("basic t1_ena off", {31'd0, m_t1}, 0);
        check("basic timeout_1", {31'd0, m_o1}, 0);
        check("basic busy off", {31'd0, m_b}, 0);
        pulse(S1);
        idle(3);
        check("done start ignored cnt", m_c1, 100);
        check("done start ignored ena", {31'd0, m_t1}, 0);
        pulse(CLR);

        // nesting: start_2 together with start_1 ignored, then 30 inside 70
        pulse(S1 | S2);
        check("nest same-edge t1", {31'd0, m_t1}, 1);
        check("nest same-edge t2", {31'd0, m_t2}, 0);
        idle(9);
        pulse(S2);
        check("nest t2_ena", {31'd0, m_t2}, 1);
        idle(29);
        pulse(P2);
        check("nest cycles_2", m_c2, 30);
        check("nest done_2", {31'd0, m_d2}, 1);
        check("nest t1 still on", {31'd0, m_t1}, 1);
        idle(29);
        pulse(P1);
        check("nest cycles_1", m_c1, 70);
        check("nest tmo cycles_1", t_c1, 50);
        check("nest tmo cycles_2", t_c2, 30);
        pulse(CLR);

        // forced stop of ch2 by stop_1; in tmo the stop coincides with timeout
        pulse(S1);
        idle(9);
        pulse(S2);
        idle(39);
        pulse(P1);
        check("forced cycles_1", m_c1, 50);
        check("forced cycles_2", m_c2, 40);
        check("forced done_2", {31'd0, m_d2}, 1);
        check("forced t2_ena", {31'd0, m_t2}, 0);
        check("forced timeout_2", {31'd0, m_o2}, 0);
        check("tmo+stop cycles_1", t_c1, 50);
        check("tmo+stop timeout_1", {31'd0, t_o1}, 1);
        check("tmo forced cycles_2", t_c2, 40);
        check("tmo forced timeout_2", {31'd0, t_o2}, 0);
        check("indep t2 keeps running", {31'd0, i_t2}, 1);
        check("indep done_2", {31'd0, i_d2}, 0);

        // clear aborts RUN, beats a same-cycle start, then a fresh start works
        pulse(CLR);
        check("clear tmo timeout_1", {31'd0, t_o1}, 0);
        pulse(S1);
        idle(4);
        pulse(S2);
        idle(3);
        pulse(CLR);
        check_all_zero("clear run");
        pulse(CLR | S1);
        check("clear beats start", {31'd0, m_t1}, 0);
        pulse(S1);
        idle(4);
        check("fresh count", m_c1, 4);

        // reset mid-run, with start/stop sampled during reset
        rst = 1'b1;
        pulse(S1);
        pulse(P1);
        rst = 1'b0;
        check_all_zero("reset run");
        step();
        check("post-reset idle", {31'd0, m_t1}, 0);
        pulse(S1);
        idle(2);
        check("post-reset count", m_c1, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
